// File: rtl/operand_fetch_if.sv
// Decode-to-execute operand fetch bundle: issue handshake, register file
// read/writeback taps and the registered execute-side handshake.
interface operand_fetch_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rj;
  logic [4:0]  in_rk;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  modport master (
    output flush, in_valid, in_pc, in_rj, in_rk,
    output in_rd, in_rd_we, rf_rdata1, rf_rdata2,
    output wb_we, wb_waddr, wb_wdata, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2,
    input  out_valid, out_pc, out_src1, out_src2,
    input  out_rd, out_rd_we
  );

  modport slave (
    input  flush, in_valid, in_pc, in_rj, in_rk,
    input  in_rd, in_rd_we, rf_rdata1, rf_rdata2,
    input  wb_we, wb_waddr, wb_wdata, out_ready,
    output in_ready, rf_raddr1, rf_raddr2,
    output out_valid, out_pc, out_src1, out_src2,
    output out_rd, out_rd_we
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: register file read with writeback bypass, scoreboard
// hazard stall and a registered valid/ready stage toward execute.
module operand_fetch #(
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  operand_fetch_if.slave bus
);

  logic [31:0] r_sb;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic [4:0]  r_rd;
  logic        r_rd_we;

  logic        w_hit_j;
  logic        w_hit_k;
  logic        w_hit_d;
  logic        w_busy_j;
  logic        w_busy_k;
  logic        w_waw;
  logic        w_hazard;
  logic        w_ready;
  logic        w_fire;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_sb_nxt;

  assign w_hit_j = bus.wb_we & (bus.wb_waddr == bus.in_rj)
                 & (bus.in_rj != 5'd0);
  assign w_hit_k = bus.wb_we & (bus.wb_waddr == bus.in_rk)
                 & (bus.in_rk != 5'd0);
  assign w_hit_d = bus.wb_we & (bus.wb_waddr == bus.in_rd)
                 & (bus.in_rd != 5'd0);

  // Without bypass a same-cycle writeback is invisible to the file read.
  assign w_busy_j = BYPASS_EN ? (r_sb[bus.in_rj] & ~w_hit_j)
                              : (r_sb[bus.in_rj] | w_hit_j);
  assign w_busy_k = BYPASS_EN ? (r_sb[bus.in_rk] & ~w_hit_k)
                              : (r_sb[bus.in_rk] | w_hit_k);

  assign w_waw = bus.in_rd_we & (bus.in_rd != 5'd0)
               & r_sb[bus.in_rd] & ~w_hit_d;

  assign w_hazard = w_busy_j | w_busy_k | w_waw;
  assign w_ready  = ~bus.flush & ~w_hazard
                  & (~r_valid | bus.out_ready);
  assign w_fire   = bus.in_valid & w_ready;

  assign w_src1 = (bus.in_rj == 5'd0)     ? 32'd0 :
                  (BYPASS_EN && w_hit_j) ? bus.wb_wdata :
                                            bus.rf_rdata1;
  assign w_src2 = (bus.in_rk == 5'd0)     ? 32'd0 :
                  (BYPASS_EN && w_hit_k) ? bus.wb_wdata :
                                            bus.rf_rdata2;

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_comb begin
    w_sb_nxt = r_sb;
    if (bus.wb_we)
      w_sb_nxt[bus.wb_waddr] = 1'b0;
    if (w_fire && bus.in_rd_we && (bus.in_rd != 5'd0))
      w_sb_nxt[bus.in_rd] = 1'b1;
    w_sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb    <= '0;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_rd    <= '0;
      r_rd_we <= 1'b0;
    end else if (bus.flush) begin
      r_sb    <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sb <= w_sb_nxt;
      if (w_fire) begin
        r_valid <= 1'b1;
        r_pc    <= bus.in_pc;
        r_src1  <= w_src1;
        r_src2  <= w_src2;
        r_rd    <= bus.in_rd;
        r_rd_we <= bus.in_rd_we & (bus.in_rd != 5'd0);
      end else if (bus.out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.rf_raddr1 = bus.in_rj;
  assign bus.rf_raddr2 = bus.in_rk;
  assign bus.out_valid = r_valid;
  assign bus.out_pc    = r_pc;
  assign bus.out_src1  = r_src1;
  assign bus.out_src2  = r_src2;
  assign bus.out_rd    = r_rd;
  assign bus.out_rd_we = r_rd_we;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: bypass and no-bypass instances run side by side
// against a register-level reference of pending writes and operand values.
module tb_operand_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  operand_fetch_if ifa ();
  operand_fetch_if ifb ();

  logic s_reset;
  logic        s_valid [2];
  logic        s_we    [2];
  logic        s_ordy  [2];
  logic        s_wbwe  [2];
  logic        s_flush [2];
  logic [4:0]  s_rj    [2];
  logic [4:0]  s_rk    [2];
  logic [4:0]  s_rd    [2];
  logic [4:0]  s_wba   [2];
  logic [31:0] s_pc    [2];
  logic [31:0] s_wbd   [2];

  logic [31:0] rf [2][32];

  logic        o_ready [2];
  logic        o_valid [2];
  logic [31:0] o_pc    [2];
  logic [31:0] o_s1    [2];
  logic [31:0] o_s2    [2];
  logic [4:0]  o_rd    [2];
  logic        o_rdwe  [2];
  logic [4:0]  o_ra1   [2];
  logic [4:0]  o_ra2   [2];

  assign ifa.flush     = s_flush[0];
  assign ifa.in_valid  = s_valid[0];
  assign ifa.in_pc     = s_pc[0];
  assign ifa.in_rj     = s_rj[0];
  assign ifa.in_rk     = s_rk[0];
  assign ifa.in_rd     = s_rd[0];
  assign ifa.in_rd_we  = s_we[0];
  assign ifa.wb_we     = s_wbwe[0];
  assign ifa.wb_waddr  = s_wba[0];
  assign ifa.wb_wdata  = s_wbd[0];
  assign ifa.out_ready = s_ordy[0];
  assign ifa.rf_rdata1 = (ifa.rf_raddr1 == 5'd0) ? 32'hFFFF_FFFF
                                                 : rf[0][ifa.rf_raddr1];
  assign ifa.rf_rdata2 = (ifa.rf_raddr2 == 5'd0) ? 32'hFFFF_FFFF
                                                 : rf[0][ifa.rf_raddr2];

  assign ifb.flush     = s_flush[1];
  assign ifb.in_valid  = s_valid[1];
  assign ifb.in_pc     = s_pc[1];
  assign ifb.in_rj     = s_rj[1];
  assign ifb.in_rk     = s_rk[1];
  assign ifb.in_rd     = s_rd[1];
  assign ifb.in_rd_we  = s_we[1];
  assign ifb.wb_we     = s_wbwe[1];
  assign ifb.wb_waddr  = s_wba[1];
  assign ifb.wb_wdata  = s_wbd[1];
  assign ifb.out_ready = s_ordy[1];
  assign ifb.rf_rdata1 = (ifb.rf_raddr1 == 5'd0) ? 32'hFFFF_FFFF
                                                 : rf[1][ifb.rf_raddr1];
  assign ifb.rf_rdata2 = (ifb.rf_raddr2 == 5'd0) ? 32'hFFFF_FFFF
                                                 : rf[1][ifb.rf_raddr2];

  assign o_ready[0] = ifa.in_ready;
  assign o_valid[0] = ifa.out_valid;
  assign o_pc[0]    = ifa.out_pc;
  assign o_s1[0]    = ifa.out_src1;
  assign o_s2[0]    = ifa.out_src2;
  assign o_rd[0]    = ifa.out_rd;
  assign o_rdwe[0]  = ifa.out_rd_we;
  assign o_ra1[0]   = ifa.rf_raddr1;
  assign o_ra2[0]   = ifa.rf_raddr2;
  assign o_ready[1] = ifb.in_ready;
  assign o_valid[1] = ifb.out_valid;
  assign o_pc[1]    = ifb.out_pc;
  assign o_s1[1]    = ifb.out_src1;
  assign o_s2[1]    = ifb.out_src2;
  assign o_rd[1]    = ifb.out_rd;
  assign o_rdwe[1]  = ifb.out_rd_we;
  assign o_ra1[1]   = ifb.rf_raddr1;
  assign o_ra2[1]   = ifb.rf_raddr2;

  operand_fetch #(.BYPASS_EN(1'b1)) dut (
    .clk   (clk),
    .reset (s_reset),
    .bus   (ifa.slave)
  );

  operand_fetch #(.BYPASS_EN(1'b0)) dut_nb (
    .clk   (clk),
    .reset (s_reset),
    .bus   (ifb.slave)
  );

  // Reference: pending-write set, registers issued downstream, stage contents.
  logic        m_valid [2];
  logic [31:0] m_pc    [2];
  logic [31:0] m_s1    [2];
  logic [31:0] m_s2    [2];
  logic [4:0]  m_rd    [2];
  logic        m_rdwe  [2];
  logic [31:0] m_pend  [2];
  logic [31:0] m_down  [2];
  bit          m_known;

  int n_cmp;
  int n_err;

  task automatic chk(input string tag, input int k,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic bit wb_to(int k, logic [4:0] x);
    return s_wbwe[k] && (s_wba[k] == x) && (x != 5'd0);
  endfunction

  // Instance 0 forwards the writeback; instance 1 must wait for the file.
  function automatic bit blocked(int k, logic [4:0] x);
    if (k == 0)
      return m_pend[k][x] && !wb_to(k, x);
    return m_pend[k][x] || wb_to(k, x);
  endfunction

  function automatic bit can_issue(int k);
    bit hz;
    hz = blocked(k, s_rj[k]) || blocked(k, s_rk[k])
      || (s_we[k] && s_rd[k] != 5'd0 && m_pend[k][s_rd[k]]
          && !wb_to(k, s_rd[k]));
    return !s_flush[k] && !hz && (!m_valid[k] || s_ordy[k]);
  endfunction

  function automatic logic [31:0] value_of(int k, logic [4:0] x);
    if (x == 5'd0) return 32'd0;
    if (k == 0 && wb_to(k, x)) return s_wbd[k];
    return rf[k][x];
  endfunction

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, 32'(o_ready[k]), 32'(can_issue(k)));
      chk("out_valid", k, 32'(o_valid[k]), 32'(m_valid[k]));
      chk("rf_raddr1", k, 32'(o_ra1[k]), 32'(s_rj[k]));
      chk("rf_raddr2", k, 32'(o_ra2[k]), 32'(s_rk[k]));
      if (m_valid[k]) begin
        chk("out_pc", k, o_pc[k], m_pc[k]);
        chk("out_src1", k, o_s1[k], m_s1[k]);
        chk("out_src2", k, o_s2[k], m_s2[k]);
        chk("out_rd", k, 32'(o_rd[k]), 32'(m_rd[k]));
        chk("out_rd_we", k, 32'(o_rdwe[k]), 32'(m_rdwe[k]));
      end
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      bit go, drained;
      logic [31:0] v1, v2;
      go      = s_valid[k] && can_issue(k);
      v1      = value_of(k, s_rj[k]);
      v2      = value_of(k, s_rk[k]);
      drained = m_valid[k] && s_ordy[k];
      if (s_reset) begin
        m_valid[k] = 0; m_pc[k] = 0; m_s1[k] = 0; m_s2[k] = 0;
        m_rd[k] = 0; m_rdwe[k] = 0; m_pend[k] = 0; m_down[k] = 0;
      end else if (s_flush[k]) begin
        m_valid[k] = 0; m_pend[k] = 0; m_down[k] = 0;
      end else begin
        if (s_wbwe[k]) begin
          m_pend[k][s_wba[k]] = 1'b0;
          m_down[k][s_wba[k]] = 1'b0;
        end
        if (drained && m_rdwe[k]) m_down[k][m_rd[k]] = 1'b1;
        if (go && s_we[k] && s_rd[k] != 5'd0)
          m_pend[k][s_rd[k]] = 1'b1;
        if (go) begin
          m_valid[k] = 1; m_pc[k] = s_pc[k];
          m_s1[k] = v1; m_s2[k] = v2; m_rd[k] = s_rd[k];
          m_rdwe[k] = s_we[k] && s_rd[k] != 5'd0;
        end else if (s_ordy[k]) begin
          m_valid[k] = 0;
        end
      end
      if (s_wbwe[k] && s_wba[k] != 5'd0) rf[k][s_wba[k]] = s_wbd[k];
    end
    if (s_reset) m_known = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (m_known) check_model();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic set_in(input bit v, input logic [4:0] j, input logic [4:0] r,
                        input logic [4:0] d, input bit we,
                        input logic [31:0] pc, input bit ordy);
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = v; s_rj[k] = j; s_rk[k] = r; s_rd[k] = d;
      s_we[k] = we; s_pc[k] = pc; s_ordy[k] = ordy;
    end
  endtask

  task automatic set_wb(input bit we, input logic [4:0] a,
                        input logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      s_wbwe[k] = we; s_wba[k] = a; s_wbd[k] = d;
    end
  endtask

  task automatic set_fl(input bit f);
    for (int k = 0; k < 2; k++) s_flush[k] = f;
  endtask

  task automatic rand_stim();
    s_reset = ($urandom % 200) == 0;
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = ($urandom % 4) != 0;
      s_rj[k]    = 5'($urandom % 8);
      s_rk[k]    = 5'($urandom % 8);
      s_rd[k]    = 5'($urandom % 8);
      s_we[k]    = 1'($urandom);
      s_pc[k]    = $urandom;
      s_ordy[k]  = ($urandom % 4) != 0;
      s_flush[k] = ($urandom % 40) == 0;
      s_wbwe[k]  = 0;
      s_wba[k]   = 0;
      s_wbd[k]   = $urandom;
      if (m_down[k] != 0 && ($urandom % 2) == 1) begin
        int st;
        st = int'($urandom % 32);
        for (int i = 0; i < 32; i++) begin
          if (m_down[k][(st + i) % 32]) begin
            s_wbwe[k] = 1;
            s_wba[k]  = 5'((st + i) % 32);
            break;
          end
        end
      end else if (($urandom % 20) == 0) begin
        s_wbwe[k] = 1;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_known = 0;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_pc[k] = 0; m_s1[k] = 0; m_s2[k] = 0;
      m_rd[k] = 0; m_rdwe[k] = 0; m_pend[k] = 0; m_down[k] = 0;
      for (int i = 0; i < 32; i++) rf[k][i] = 32'h1000_0000 + i * 7;
      rf[k][1] = 32'h11;
      rf[k][2] = 32'h22;
    end
    set_in(0, 0, 0, 0, 0, 0, 1);
    set_wb(0, 0, 0);
    set_fl(0);
    s_reset = 1;
    tick();
    tick();
    s_reset = 0;
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", k, 32'(o_valid[k]), 32'd0);
      chk("reset_pc", k, o_pc[k], 32'd0);
    end

    set_in(1, 1, 2, 3, 1, 32'h100, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("first_src1", k, o_s1[k], 32'h11);
      chk("first_src2", k, o_s2[k], 32'h22);
      chk("first_rd", k, 32'(o_rd[k]), 32'd3);
    end

    set_in(1, 3, 0, 4, 1, 32'h104, 1);
    #1;
    chk("raw_stall", 0, 32'(o_ready[0]), 32'd0);
    chk("raw_stall", 1, 32'(o_ready[1]), 32'd0);
    tick();
    set_wb(1, 3, 32'hABCD);
    #1;
    chk("raw_wb_byp", 0, 32'(o_ready[0]), 32'd1);
    chk("raw_wb_nobyp", 1, 32'(o_ready[1]), 32'd0);
    tick();
    chk("raw_fwd_src1", 0, o_s1[0], 32'hABCD);
    set_wb(0, 0, 0);
    #1;
    chk("raw_late_ready", 1, 32'(o_ready[1]), 32'd1);
    tick();
    chk("raw_late_src1", 1, o_s1[1], 32'hABCD);

    set_in(1, 0, 0, 0, 1, 32'h300, 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("r0_src1", k, o_s1[k], 32'd0);
      chk("r0_rd_we", k, 32'(o_rdwe[k]), 32'd0);
    end

    set_in(1, 1, 2, 6, 1, 32'h200, 0);
    #1;
    chk("bp_ready", 0, 32'(o_ready[0]), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_pc", 0, o_pc[0], 32'h300);
      chk("bp_hold_pc", 1, o_pc[1], 32'h300);
    end
    set_in(1, 1, 2, 6, 1, 32'h200, 1);
    #1;
    chk("bp_release", 0, 32'(o_ready[0]), 32'd1);
    tick();
    chk("bp_new_pc", 0, o_pc[0], 32'h200);

    set_in(1, 1, 2, 6, 1, 32'h204, 1);
    #1;
    chk("waw_stall", 0, 32'(o_ready[0]), 32'd0);
    set_wb(1, 6, 32'h5555);
    #1;
    chk("waw_wb", 0, 32'(o_ready[0]), 32'd1);
    chk("waw_wb", 1, 32'(o_ready[1]), 32'd1);
    tick();
    set_wb(0, 0, 0);
    #1;
    chk("waw_reset_bit", 0, 32'(o_ready[0]), 32'd0);

    set_fl(1);
    tick();
    set_fl(0);
    chk("flush_valid", 0, 32'(o_valid[0]), 32'd0);
    set_in(1, 4, 6, 6, 1, 32'h208, 1);
    #1;
    chk("flush_sb_clear", 0, 32'(o_ready[0]), 32'd1);
    tick();

    set_in(1, 6, 0, 7, 1, 32'h20C, 1);
    #1;
    chk("mid_stall", 0, 32'(o_ready[0]), 32'd0);
    s_reset = 1;
    tick();
    s_reset = 0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(o_valid[k]), 32'd0);
      chk("rst_pc", k, o_pc[k], 32'd0);
      chk("rst_src1", k, o_s1[k], 32'd0);
      chk("rst_src2", k, o_s2[k], 32'd0);
      chk("rst_rd", k, 32'(o_rd[k]), 32'd0);
      chk("rst_rd_we", k, 32'(o_rdwe[k]), 32'd0);
    end
    #1;
    chk("rst_ready", 0, 32'(o_ready[0]), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      rand_stim();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side reader of the 32x32 general register file (2 async read ports, 1 sync write port, r0 hard-wired to 0).
- Drives both read addresses and bypasses the same-cycle writeback value, because the file updates only on the next edge.
- Tracks pending destination writes in a 32-bit scoreboard and stalls RAW/WAW hazards.
- Delivers resolved operands to the execute stage through a registered valid/ready stage.

Parameters:
BYPASS_EN, 1, 1: forward wb_wdata when wb_waddr matches a source; 0: treat a matching write as a hazard and stall one cycle.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
flush  input  1  pipeline kill (branch redirect/exception)
in_valid  input  1  decoded instruction present
in_ready  output  1  instruction accepted this cycle when in_valid&in_ready
in_pc  input  32  instruction PC (payload)
in_rj  input  5  source 1 index
in_rk  input  5  source 2 index
in_rd  input  5  destination index
in_rd_we  input  1  instruction writes in_rd
rf_raddr1  output  5  register file read address 1 (=in_rj)
rf_raddr2  output  5  register file read address 2 (=in_rk)
rf_rdata1  input  32  register file read data 1 (combinational)
rf_rdata2  input  32  register file read data 2 (combinational)
wb_we  input  1  writeback valid (same signal driving the file's we)
wb_waddr  input  5  writeback index
wb_wdata  input  32  writeback data
out_valid  output  1  operands valid to execute
out_ready  input  1  execute accepts
out_pc  output  32  registered in_pc
out_src1  output  32  resolved rj value
out_src2  output  32  resolved rk value
out_rd  output  5  registered in_rd
out_rd_we  output  1  registered in_rd_we (forced 0 when in_rd==0)

Behaviour:
- Reset: out_valid=0; scoreboard sb=0; out_pc/out_src1/out_src2=0; out_rd=0; out_rd_we=0.
- sb[0] is constantly 0; writes to index 0 never set it.
- wb_hit(x) = wb_we & (wb_waddr==x) & (x!=0).
- busy(x) = sb[x] & !(BYPASS_EN & wb_hit(x)).
  - BYPASS_EN=0: busy(x) = sb[x] | wb_hit(x).
- hazard = busy(in_rj) | busy(in_rk) | (in_rd_we & in_rd!=0 & sb[in_rd] & !wb_hit(in_rd)).
  - The WAW term waits for the older write to complete.
  - All source checks apply even for unused fields; decode zeroes unused indices.
- in_ready = !flush & !hazard & (!out_valid | out_ready). This is combinational; no dependence on in_valid.
- fire = in_valid & in_ready.
- Operand select, per port:
  - index 0 -> 0.
  - else BYPASS_EN & wb_hit -> wb_wdata.
  - else rf_rdata.
- Output stage:
  - On fire: load all out_* registers; out_valid=1.
  - Else if out_ready: out_valid=0.
  - Else hold.
  - Latency: in→out 1 cycle; back-to-back issue is sustained when no hazard.
- Scoreboard update at each edge, in order:
  1. Clear sb[wb_waddr] if wb_we.
  2. Set sb[in_rd] if fire & in_rd_we & in_rd!=0.
  - Set wins on the same index in the same cycle.
  - A clear of a non-set bit is harmless.
- flush (highest priority after reset):
  - Next edge: out_valid=0, sb=0, no fire.
  - A same-cycle wb is ignored for sb.
  - Contract: flush is asserted only when every issued-but-unwritten instruction downstream is also killed.
- Writeback of one instruction per cycle only. The scoreboard supports a single in-flight write per register (guaranteed by the WAW stall).
- reset mid-operation: all state returns to reset values at the next edge, regardless of flush/fire.

Test Plan:
- After reset, issue rj=1,rk=2,rd=3,we=1 with rf_rdata1=0x11, rf_rdata2=0x22, out_ready=1 -> next cycle out_valid=1, out_src1=0x11, out_src2=0x22, out_rd=3, sb[3]=1.
- RAW stall: after the above, issue rj=3 -> in_ready=0 until wb_we=1, wb_waddr=3, wb_wdata=0xABCD. In that cycle in_ready=1 and out_src1=0xABCD the next cycle (BYPASS_EN=1); with BYPASS_EN=0 issue occurs one cycle later with out_src1 taken from rf_rdata1.
- r0 rules: rj=0 with rf_rdata1=0xFFFFFFFF -> out_src1=0. rd=0, we=1 -> out_rd_we=0, sb unchanged. wb to r0 never bypasses.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and all out_* held stable 3 cycles. out_ready=1 -> the next instruction fires the same cycle.
- WAW/simultaneous: sb[5]=1, issue rd=5 in the same cycle as wb to 5 -> fire allowed and sb[5]=1 after the edge. Without the wb, in_ready=0.
- flush with out_valid=1, sb=0x0000_0028, in_valid=1 -> next cycle out_valid=0, sb=0, no new out_* load. Reset asserted mid-stall -> identical reset values.
